// File: rtl/serial_add_driver_pkg.sv
// Shared definitions for the serial adder initiator: state encoding and
// default geometry of the operand/sum path.
package serial_add_driver_pkg;

   localparam int unsigned DEF_WIDTH     = 8;
   localparam int unsigned DEF_ADDER_LAT = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_SHIFT = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/serial_add_shifter.sv
// Operand PISO pair (A/B, LSB-first) plus sum SIPO filled from the MSB side.
// Controls: load captures operands, shift_out advances A/B, shift_in takes one sum bit.
module serial_add_shifter
   import serial_add_driver_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load_i,
   input  logic             shift_out_i,
   input  logic             shift_in_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             s_i,
   output logic             a_lsb_o,
   output logic             b_lsb_o,
   output logic [WIDTH-1:0] sum_o
);

   logic [WIDTH-1:0] a_q, b_q, sum_q;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_q   <= '0;
         b_q   <= '0;
         sum_q <= '0;
      end else begin
         if (load_i) begin
            a_q <= a_i;
            b_q <= b_i;
         end else if (shift_out_i) begin
            a_q <= {1'b0, a_q[WIDTH-1:1]};
            b_q <= {1'b0, b_q[WIDTH-1:1]};
         end
         if (shift_in_i) begin
            sum_q <= {s_i, sum_q[WIDTH-1:1]};
         end
      end
   end

   assign a_lsb_o = a_q[0];
   assign b_lsb_o = b_q[0];
   assign sum_o   = sum_q;

endmodule

// File: rtl/serial_add_driver.sv
// Parallel-to-serial initiator for a bit-serial adder: clears the adder, streams
// operands LSB-first, gathers the delayed sum bits and returns the parallel result.
module serial_add_driver
   import serial_add_driver_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned ADDER_LAT = DEF_ADDER_LAT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             sa_start,
   output logic             sa_rst,
   output logic             sa_a,
   output logic             sa_b,
   output logic             sa_cin,
   input  logic             sa_s,
   input  logic             sa_cout,
   output logic             busy
);

   localparam int unsigned   CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e         state_q, state_d;
   logic           req_ready_q, req_ready_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_cout_q, rsp_cout_d;
   logic           sa_start_q, sa_start_d;
   logic           sa_rst_q, sa_rst_d;
   logic           sa_a_q, sa_a_d;
   logic           sa_b_q, sa_b_d;
   logic           sa_cin_q, sa_cin_d;
   logic           cin_q, cin_d;
   logic           busy_q, busy_d;
   logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]  cap_cnt_q, cap_cnt_d;
   // drv_q marks a cycle in which a bit is on sa_a/sa_b; the pipe ages it to the capture slot.
   logic                 drv_q, drv_d;
   logic [ADDER_LAT-1:0] vld_pipe_q, vld_pipe_d;

   logic load, shift_out, shift_in, capture;
   logic a_lsb, b_lsb;

   serial_add_shifter #(.WIDTH(WIDTH)) u_shifter (
      .CLK         (CLK),
      .RST         (RST),
      .load_i      (load),
      .shift_out_i (shift_out),
      .shift_in_i  (shift_in),
      .a_i         (op_a),
      .b_i         (op_b),
      .s_i         (sa_s),
      .a_lsb_o     (a_lsb),
      .b_lsb_o     (b_lsb),
      .sum_o       (rsp_sum)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_cout_q  <= 1'b0;
         sa_start_q  <= 1'b0;
         sa_rst_q    <= 1'b0;
         sa_a_q      <= 1'b0;
         sa_b_q      <= 1'b0;
         sa_cin_q    <= 1'b0;
         cin_q       <= 1'b0;
         busy_q      <= 1'b0;
         bit_cnt_q   <= '0;
         cap_cnt_q   <= '0;
         drv_q       <= 1'b0;
         vld_pipe_q  <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_cout_q  <= rsp_cout_d;
         sa_start_q  <= sa_start_d;
         sa_rst_q    <= sa_rst_d;
         sa_a_q      <= sa_a_d;
         sa_b_q      <= sa_b_d;
         sa_cin_q    <= sa_cin_d;
         cin_q       <= cin_d;
         busy_q      <= busy_d;
         bit_cnt_q   <= bit_cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         drv_q       <= drv_d;
         vld_pipe_q  <= vld_pipe_d;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      req_ready_d = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_cout_d  = rsp_cout_q;
      sa_start_d  = 1'b0;
      sa_rst_d    = 1'b0;
      sa_a_d      = 1'b0;
      sa_b_d      = 1'b0;
      sa_cin_d    = 1'b0;
      cin_d       = cin_q;
      bit_cnt_d   = bit_cnt_q;
      cap_cnt_d   = cap_cnt_q;
      drv_d       = 1'b0;
      load        = 1'b0;
      shift_out   = 1'b0;
      shift_in    = 1'b0;

      vld_pipe_d[0] = drv_q;
      for (int i = 1; i < ADDER_LAT; i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1];
      end
      capture = vld_pipe_q[ADDER_LAT-1] && (state_q == ST_SHIFT || state_q == ST_DRAIN);

      // Outputs are computed for the state being entered, so they register in step with it.
      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               load        = 1'b1;
               cin_d       = op_cin;
               cap_cnt_d   = '0;
               sa_rst_d    = 1'b1;
               req_ready_d = 1'b0;
               state_d     = ST_CLR;
            end
         end
         ST_CLR: begin
            sa_a_d     = a_lsb;
            sa_b_d     = b_lsb;
            sa_start_d = 1'b1;
            sa_cin_d   = cin_q;
            drv_d      = 1'b1;
            shift_out  = 1'b1;
            bit_cnt_d  = '0;
            state_d    = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (bit_cnt_q == LAST) begin
               state_d = ST_DRAIN;
            end else begin
               sa_a_d    = a_lsb;
               sa_b_d    = b_lsb;
               drv_d     = 1'b1;
               shift_out = 1'b1;
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
         ST_DRAIN: begin
         end
         ST_DONE: begin
            rsp_valid_d = 1'b1;
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The final bit always lands after SHIFT, so this never overrides a SHIFT transition.
      if (capture) begin
         shift_in  = 1'b1;
         cap_cnt_d = cap_cnt_q + CW'(1);
         if (cap_cnt_q == LAST) begin
            cap_cnt_d   = '0;
            rsp_cout_d  = sa_cout;
            rsp_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_cout  = rsp_cout_q;
   assign sa_start  = sa_start_q;
   assign sa_rst    = sa_rst_q;
   assign sa_a      = sa_a_q;
   assign sa_b      = sa_b_q;
   assign sa_cin    = sa_cin_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_serial_add_driver.sv
// Directed bench: two drivers (8-bit/lat 1 and 4-bit/lat 3), each paired with a
// behavioural serial adder; results compared against hand-computed sums.
module tb_serial_add_driver;

   localparam int unsigned W0 = 8, L0 = 1;
   localparam int unsigned W1 = 4, L1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- instance 0 ----------------
   logic          rst0 = 1'b1, req_valid0 = 1'b0, op_cin0 = 1'b0, rsp_ready0 = 1'b0;
   logic [W0-1:0] op_a0 = '0, op_b0 = '0;
   logic          req_ready0, rsp_valid0, rsp_cout0, busy0;
   logic [W0-1:0] rsp_sum0;
   logic          sa_start0, sa_rst0, sa_a0, sa_b0, sa_cin0, sa_s0, sa_cout0;

   serial_add_driver #(.WIDTH(W0), .ADDER_LAT(L0)) dut0 (
      .CLK(clk), .RST(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
      .op_a(op_a0), .op_b(op_b0), .op_cin(op_cin0), .rsp_valid(rsp_valid0),
      .rsp_ready(rsp_ready0), .rsp_sum(rsp_sum0), .rsp_cout(rsp_cout0),
      .sa_start(sa_start0), .sa_rst(sa_rst0), .sa_a(sa_a0), .sa_b(sa_b0),
      .sa_cin(sa_cin0), .sa_s(sa_s0), .sa_cout(sa_cout0), .busy(busy0)
   );

   logic          carry0 = 1'b0;
   logic [L0-1:0] s_pipe0 = '0, c_pipe0 = '0;
   logic          cin_eff0, s_now0, co_now0;
   always_comb begin
      cin_eff0 = sa_start0 ? sa_cin0 : carry0;
      s_now0   = sa_a0 ^ sa_b0 ^ cin_eff0;
      co_now0  = (sa_a0 & sa_b0) | (sa_a0 & cin_eff0) | (sa_b0 & cin_eff0);
   end
   always @(posedge clk) begin
      carry0 <= sa_rst0 ? 1'b0 : co_now0;
      for (int i = 0; i < L0; i++) begin
         s_pipe0[i] <= (i == 0) ? s_now0  : s_pipe0[i-1];
         c_pipe0[i] <= (i == 0) ? co_now0 : c_pipe0[i-1];
      end
   end
   assign sa_s0    = s_pipe0[L0-1];
   assign sa_cout0 = c_pipe0[L0-1];

   // ---------------- instance 1 ----------------
   logic          rst1 = 1'b1, req_valid1 = 1'b0, op_cin1 = 1'b0, rsp_ready1 = 1'b1;
   logic [W1-1:0] op_a1 = '0, op_b1 = '0;
   logic          req_ready1, rsp_valid1, rsp_cout1, busy1;
   logic [W1-1:0] rsp_sum1;
   logic          sa_start1, sa_rst1, sa_a1, sa_b1, sa_cin1, sa_s1, sa_cout1;

   serial_add_driver #(.WIDTH(W1), .ADDER_LAT(L1)) dut1 (
      .CLK(clk), .RST(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
      .op_a(op_a1), .op_b(op_b1), .op_cin(op_cin1), .rsp_valid(rsp_valid1),
      .rsp_ready(rsp_ready1), .rsp_sum(rsp_sum1), .rsp_cout(rsp_cout1),
      .sa_start(sa_start1), .sa_rst(sa_rst1), .sa_a(sa_a1), .sa_b(sa_b1),
      .sa_cin(sa_cin1), .sa_s(sa_s1), .sa_cout(sa_cout1), .busy(busy1)
   );

   logic          carry1 = 1'b0;
   logic [L1-1:0] s_pipe1 = '0, c_pipe1 = '0;
   logic          cin_eff1, s_now1, co_now1;
   always_comb begin
      cin_eff1 = sa_start1 ? sa_cin1 : carry1;
      s_now1   = sa_a1 ^ sa_b1 ^ cin_eff1;
      co_now1  = (sa_a1 & sa_b1) | (sa_a1 & cin_eff1) | (sa_b1 & cin_eff1);
   end
   always @(posedge clk) begin
      carry1 <= sa_rst1 ? 1'b0 : co_now1;
      for (int i = 0; i < L1; i++) begin
         s_pipe1[i] <= (i == 0) ? s_now1  : s_pipe1[i-1];
         c_pipe1[i] <= (i == 0) ? co_now1 : c_pipe1[i-1];
      end
   end
   assign sa_s1    = s_pipe1[L1-1];
   assign sa_cout1 = c_pipe1[L1-1];

   // One full transaction on instance 0. hold = cycles rsp_ready stays low after
   // rsp_valid rises; poke = pulse a conflicting request during SHIFT.
   task automatic txn0(input string tag, input logic [W0-1:0] a, input logic [W0-1:0] b,
                       input logic cin, input logic [W0-1:0] es, input logic ec,
                       input int hold, input bit poke);
      int c, vcyc, rst_hits, rst_cyc, st_hits, st_cyc;
      rsp_ready0 = (hold == 0);
      @(negedge clk);
      check({tag, "_req_ready"}, req_ready0, 1);
      req_valid0 = 1'b1; op_a0 = a; op_b0 = b; op_cin0 = cin;
      @(negedge clk);
      req_valid0 = 1'b0; op_a0 = ~a; op_b0 = ~b; op_cin0 = ~cin;
      c = 1; vcyc = 0; rst_hits = 0; rst_cyc = 0; st_hits = 0; st_cyc = 0;
      while (vcyc == 0 && c < 60) begin
         if (sa_rst0)   begin rst_hits++; rst_cyc = c; end
         if (sa_start0) begin st_hits++;  st_cyc  = c; end
         if (poke) begin
            req_valid0 = (c == 4);
            op_a0 = 8'hFF; op_b0 = 8'hFF; op_cin0 = 1'b1;
         end
         if (rsp_valid0) vcyc = c;
         else begin
            @(negedge clk);
            c++;
         end
      end
      req_valid0 = 1'b0;
      check({tag, "_latency"}, vcyc, W0 + 2 + L0);
      check({tag, "_sa_rst"}, {rst_hits[7:0], rst_cyc[7:0]}, {8'd1, 8'd1});
      check({tag, "_sa_start"}, {st_hits[7:0], st_cyc[7:0]}, {8'd1, 8'd2});
      check({tag, "_sum"}, rsp_sum0, es);
      check({tag, "_cout"}, rsp_cout0, ec);
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check({tag, "_held"}, {rsp_valid0, req_ready0, rsp_cout0, rsp_sum0},
               {1'b1, 1'b0, ec, es});
         rsp_ready0 = 1'b1;
      end
      @(negedge clk);
      check({tag, "_idle"}, {busy0, rsp_valid0, req_ready0}, 3'b001);
      if (poke) begin
         repeat (3) @(negedge clk);
         check({tag, "_no_second"}, {busy0, rsp_valid0}, 2'b00);
      end
   endtask

   task automatic txn1(input string tag, input logic [W1-1:0] a, input logic [W1-1:0] b,
                       input logic cin, input logic [W1-1:0] es, input logic ec);
      int c;
      @(negedge clk);
      check({tag, "_req_ready"}, req_ready1, 1);
      req_valid1 = 1'b1; op_a1 = a; op_b1 = b; op_cin1 = cin;
      @(negedge clk);
      req_valid1 = 1'b0; op_a1 = ~a; op_b1 = ~b;
      c = 1;
      while (!rsp_valid1 && c < 60) begin
         @(negedge clk);
         c++;
      end
      check({tag, "_latency"}, c, W1 + 2 + L1);
      check({tag, "_result"}, {rsp_cout1, rsp_sum1}, {ec, es});
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outs0", {req_ready0, rsp_valid0, busy0, rsp_cout0, rsp_sum0}, '0);
      check("reset_sa0", {sa_rst0, sa_start0, sa_a0, sa_b0, sa_cin0}, '0);
      rst0 = 1'b0; rst1 = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {req_ready0, req_ready1}, 2'b11);

      txn0("basic",   8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 1'b0);
      txn0("carry1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
      txn0("carry2",  8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0, 1'b0);
      txn0("backp",   8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 5, 1'b0);
      txn0("ignored", 8'h21, 8'h43, 1'b1, 8'h65, 1'b0, 0, 1'b1);

      // Abort mid-SHIFT: bit 4 is on the wire in cycle 6.
      rsp_ready0 = 1'b1;
      @(negedge clk);
      req_valid0 = 1'b1; op_a0 = 8'hFF; op_b0 = 8'hFF; op_cin0 = 1'b1;
      @(negedge clk);
      req_valid0 = 1'b0;
      repeat (5) @(negedge clk);
      rst0 = 1'b1;
      @(negedge clk);
      check("abort_state", {busy0, rsp_valid0, req_ready0, rsp_sum0}, '0);
      check("abort_sa", {sa_rst0, sa_start0, sa_a0, sa_b0, sa_cin0}, '0);
      rst0 = 1'b0;
      @(negedge clk);
      check("abort_ready", req_ready0, 1);
      repeat (15) @(negedge clk);
      check("abort_no_rsp", {rsp_valid0, busy0}, 2'b00);
      txn0("post_abort", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b0);

      txn1("b2b_first",  4'h9, 4'h8, 1'b0, 4'h1, 1'b1);
      txn1("b2b_second", 4'h7, 4'h7, 1'b1, 4'hF, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
